regfile_param: RTL and testbench
================================

# regfile_param

Parametrised register file for the lab CPU datapath. It is the next generation of the fixed 8×8-bit file: width, depth and first-port window are parameters, and it adds a synchronous reset and a sequenced bulk-clear engine. It keeps the existing hardwired-zero, immediate-with-carry, branch-register and swap semantics. It sits between decode (addresses, control) and the ALU/branch unit (read values).

## Interface
- WIDTH, 8: data width of every register and data port.
- NREGS, 8: register count. Power of two, ≥4. AW = log2(NREGS).
- RD1_REGS, 4: registers visible to read port 1 (indices 0..RD1_REGS-1). Power of two, ≤NREGS. A1W = log2(RD1_REGS).
- IMM_IDX, 1: index of the immediate register. Must be <RD1_REGS and ≠0.
- BR_IDX, NREGS-1: index of the branch register.

- clock  in  1  single clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- write_ctrl  in  1  write enable
- carry_out  in  1  ALU carry; forces imm←1 on a write
- swap_ctrl  in  1  exchange reg[read_reg1] and reg[read_reg2]
- set_ctrl  in  2  port-1 override: 1x selects imm (x=0) or branch (x=1)
- read_reg1  in  A1W  port-1 address
- read_reg2  in  AW  port-2 address
- write_reg  in  AW  write address
- write_val  in  WIDTH  write data
- clear_req  in  1  start bulk clear (pulse)
- read_val1  out  WIDTH  port-1 data
- read_val2  out  WIDTH  port-2 data
- branch_val  out  WIDTH  reg[BR_IDX], always
- clear_busy  out  1  high while the clear sequencer runs

## Operation
- reg[0] reads 0 always. Writes and swaps targeting index 0 are dropped.
- Reads are combinational from committed state. There is no write bypass.
  - read_val1 = set_ctrl[1] ? (set_ctrl[0] ? reg[BR_IDX] : reg[IMM_IDX]) : reg[read_reg1].
  - read_val2 = reg[read_reg2].
- Write (write_ctrl=1, carry_out=0): reg[write_reg] ← write_val.
- Write with carry (write_ctrl=1, carry_out=1):
  - reg[IMM_IDX] ← 1 (zero-extended to WIDTH).
  - reg[write_reg] ← write_val, unless write_reg==IMM_IDX, in which case imm gets 1.
- Swap (swap_ctrl=1):
  - reg[read_reg1] ← old reg[read_reg2] and reg[read_reg2] ← old reg[read_reg1].
  - Swap uses raw register contents and ignores set_ctrl.
  - Equal addresses: no change.
- Per-register priority in one cycle: reset > clear sequencer > swap > carry imm-set > normal write. A write to a register not involved in the swap still commits in the same cycle.
- Clear FSM, states IDLE and CLEAR, with counter idx (AW bits):
  - IDLE and clear_req=1 → CLEAR, idx←1.
  - CLEAR: reg[idx]←0, idx←idx+1. After clearing index NREGS-1 → IDLE.
  - clear_busy = (state==CLEAR).
  - While busy: write_ctrl, swap_ctrl and clear_req are ignored (dropped, not queued). Reads stay live and show partially cleared contents.
- Reset: all registers 0, state IDLE, idx 0. Outputs after reset: read_val1/read_val2/branch_val = 0, clear_busy = 0.

## Timing
- Write/swap/clear effects are visible on read ports the cycle after the posedge that commits them.
- Read latency is 0 cycles (combinational) from address or set_ctrl change.
- Clear takes exactly NREGS-1 cycles: clear_busy is high for NREGS-1 cycles starting the cycle after clear_req is sampled. The first write is accepted on the edge where clear_busy is low again.
- Reset asserted mid-clear aborts to IDLE and zeroes everything on that edge. clear_busy is 0 the next cycle.
- clear_req held high continuously restarts the clear immediately upon return to IDLE. This is acceptable; the requester pulses clear_req.

## Structure
- Shared package regfile_pkg: state enum {IDLE, CLEAR}, set_ctrl encodings (SET_NONE=2'b0x, SET_IMM=2'b10, SET_BR=2'b11), default IMM_IDX.
- Storage is a single array reg[NREGS] with generate-loop per-register next-state logic implementing the priority chain.
- One sub-module: regfile_clear_seq (FSM plus idx counter; outputs clear_busy, clear_en, clear_idx).

## Test plan
- Reset, then write t1 (idx 2) ← 8'hA5; next cycle read_reg2=2 → read_val2=8'hA5; write idx 0 ← 8'hFF → read_val2 at addr 0 = 0.
- write_ctrl=1, carry_out=1, write_reg=4, write_val=8'h3C → reg4=8'h3C, imm=1; repeat with write_reg=IMM_IDX, write_val=8'h77 → imm=1.
- reg2=8'h11, reg6=8'h66; swap read_reg1=2, read_reg2=6 with set_ctrl=2'b10 → reg2=8'h66, reg6=8'h11; simultaneous write to reg3 ← 8'h33 also lands.
- Fill all registers with 8'hFF; pulse clear_req → clear_busy high exactly 7 cycles (NREGS=8), write attempted mid-clear dropped, all registers 0 at end.
- Start clear, assert reset on clear cycle 3 → next cycle clear_busy=0, all registers 0, new clear_req accepted normally.
- Re-run the first and fourth scenarios with WIDTH=16, NREGS=16, RD1_REGS=8 → same behaviour; clear lasts 15 cycles; branch_val tracks reg15.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and constants for the parametrised register file and its
// bulk-clear sequencer.
package regfile_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_e;

    // Port-1 override encodings; any value with bit 1 low means no override.
    localparam logic [1:0] SET_IMM = 2'b10;
    localparam logic [1:0] SET_BR  = 2'b11;

    localparam int DEFAULT_IMM_IDX = 1;

endpackage

// File: rtl/regfile_clear_seq.sv
// Bulk-clear sequencer: walks idx from 1 to NREGS-1, one register per cycle.
// Index 0 is hardwired zero, so it is skipped.
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter  int NREGS = 8,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clear_req,
    output logic          clear_busy,
    output logic          clear_en,
    output logic [AW-1:0] clear_idx
);

    clr_state_e    state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (clear_req) begin
                    state_d = CLEAR;
                    idx_d   = AW'(1);
                end
            end
            CLEAR: begin
                // idx wraps to 0 after the last register, ready for the next run.
                idx_d = idx_q + AW'(1);
                if (idx_q == AW'(NREGS - 1)) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    assign clear_busy = (state_q == CLEAR);
    assign clear_en   = (state_q == CLEAR);
    assign clear_idx  = idx_q;

endmodule

// File: rtl/regfile_param.sv
// Parametrised register file: hardwired-zero r0, immediate-with-carry,
// branch register, register swap and a sequenced bulk clear.
module regfile_param
    import regfile_pkg::*;
#(
    parameter  int WIDTH    = 8,
    parameter  int NREGS    = 8,
    parameter  int RD1_REGS = 4,
    parameter  int IMM_IDX  = DEFAULT_IMM_IDX,
    parameter  int BR_IDX   = NREGS - 1,
    localparam int AW       = $clog2(NREGS),
    localparam int A1W      = $clog2(RD1_REGS)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             write_ctrl,
    input  logic             carry_out,
    input  logic             swap_ctrl,
    input  logic [1:0]       set_ctrl,
    input  logic [A1W-1:0]   read_reg1,
    input  logic [AW-1:0]    read_reg2,
    input  logic [AW-1:0]    write_reg,
    input  logic [WIDTH-1:0] write_val,
    input  logic             clear_req,
    output logic [WIDTH-1:0] read_val1,
    output logic [WIDTH-1:0] read_val2,
    output logic [WIDTH-1:0] branch_val,
    output logic             clear_busy
);

    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] regs_d [NREGS];

    logic          clear_en;
    logic [AW-1:0] clear_idx;
    logic [AW-1:0] rd1_addr;
    logic          swap_ok;
    logic          carry_set;

    regfile_clear_seq #(
        .NREGS (NREGS)
    ) u_clear_seq (
        .clock      (clock),
        .reset      (reset),
        .clear_req  (clear_req),
        .clear_busy (clear_busy),
        .clear_en   (clear_en),
        .clear_idx  (clear_idx)
    );

    assign rd1_addr  = AW'(read_reg1);
    assign swap_ok   = swap_ctrl && (rd1_addr != read_reg2);
    assign carry_set = write_ctrl && carry_out;

    // Per-register priority: clear > swap > carry imm-set > normal write.
    // While clearing, every register not being cleared simply holds.
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
        localparam logic [AW-1:0] IDX    = AW'(gi);
        localparam bit            IS_IMM = (gi == IMM_IDX);

        if (gi == 0) begin : g_zero
            assign regs_d[gi] = '0;
        end else begin : g_live
            assign regs_d[gi] =
                clear_en                              ? ((clear_idx == IDX) ? '0 : regs_q[gi]) :
                (swap_ok && rd1_addr == IDX)          ? regs_q[read_reg2] :
                (swap_ok && read_reg2 == IDX)         ? regs_q[rd1_addr] :
                (carry_set && IS_IMM)                 ? WIDTH'(1) :
                (write_ctrl && write_reg == IDX)      ? write_val :
                                                        regs_q[gi];
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < NREGS; i++) begin
            if (reset) begin
                regs_q[i] <= '0;
            end else begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    always_comb begin
        read_val1 = regs_q[rd1_addr];
        if (set_ctrl == SET_BR) begin
            read_val1 = regs_q[BR_IDX];
        end else if (set_ctrl == SET_IMM) begin
            read_val1 = regs_q[IMM_IDX];
        end
    end

    assign read_val2  = regs_q[read_reg2];
    assign branch_val = regs_q[BR_IDX];

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param: directed vector table, clear/reset
// sequences, a 16-register instance, and randomized traffic against a model.
module tb_regfile_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 8 x 8-bit instance (defaults)
    logic       a_rst, a_wc, a_co, a_sw, a_creq;
    logic [1:0] a_sc, a_r1;
    logic [2:0] a_r2, a_wr;
    logic [7:0] a_wv, a_rv1, a_rv2, a_bv;
    logic       a_busy;

    regfile_param u_a (
        .clock(clk), .reset(a_rst), .write_ctrl(a_wc), .carry_out(a_co),
        .swap_ctrl(a_sw), .set_ctrl(a_sc), .read_reg1(a_r1), .read_reg2(a_r2),
        .write_reg(a_wr), .write_val(a_wv), .clear_req(a_creq),
        .read_val1(a_rv1), .read_val2(a_rv2), .branch_val(a_bv), .clear_busy(a_busy)
    );

    // 16 x 16-bit instance
    logic        b_rst, b_wc, b_co, b_sw, b_creq;
    logic [1:0]  b_sc;
    logic [2:0]  b_r1;
    logic [3:0]  b_r2, b_wr;
    logic [15:0] b_wv, b_rv1, b_rv2, b_bv;
    logic        b_busy;

    regfile_param #(.WIDTH(16), .NREGS(16), .RD1_REGS(8)) u_b (
        .clock(clk), .reset(b_rst), .write_ctrl(b_wc), .carry_out(b_co),
        .swap_ctrl(b_sw), .set_ctrl(b_sc), .read_reg1(b_r1), .read_reg2(b_r2),
        .write_reg(b_wr), .write_val(b_wv), .clear_req(b_creq),
        .read_val1(b_rv1), .read_val2(b_rv2), .branch_val(b_bv), .clear_busy(b_busy)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs change 2 time units after the edge; outputs are checked 1 unit later.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    typedef struct {
        logic       wc, co, sw;
        logic [1:0] sc, r1;
        logic [2:0] r2, wr;
        logic [7:0] wv, e1, e2;
    } vec_t;

    function automatic vec_t mk(int wc, int co, int sw, int sc, int r1, int r2,
                                int wr, int wv, int e1, int e2);
        vec_t v;
        v.wc = wc[0]; v.co = co[0]; v.sw = sw[0];
        v.sc = sc[1:0]; v.r1 = r1[1:0]; v.r2 = r2[2:0]; v.wr = wr[2:0];
        v.wv = wv[7:0]; v.e1 = e1[7:0]; v.e2 = e2[7:0];
        return v;
    endfunction

    vec_t vt[14];

    // Reference model state for the 8-register instance
    int m[8];
    int nm[8];
    int busy_left;
    int clr_next;
    int n;
    int exp1;

    initial begin
        // Each row: action applied at the next edge; e1/e2 are the reads
        // of already-committed state seen before that edge.
        //        wc co sw sc r1 r2 wr wv     e1     e2
        vt[0]  = mk(1, 0, 0, 0, 0, 2, 2, 'hA5, 'h00, 'h00);
        vt[1]  = mk(1, 0, 0, 0, 0, 2, 0, 'hFF, 'h00, 'hA5);
        vt[2]  = mk(1, 1, 0, 0, 0, 0, 4, 'h3C, 'h00, 'h00);
        vt[3]  = mk(1, 1, 0, 2, 0, 4, 1, 'h77, 'h01, 'h3C);
        vt[4]  = mk(1, 0, 0, 2, 0, 1, 1, 'h05, 'h01, 'h01);
        vt[5]  = mk(1, 0, 0, 2, 0, 1, 2, 'h11, 'h05, 'h05);
        vt[6]  = mk(1, 0, 0, 0, 0, 2, 6, 'h66, 'h00, 'h11);
        vt[7]  = mk(1, 0, 1, 2, 2, 6, 3, 'h33, 'h05, 'h66);
        vt[8]  = mk(0, 0, 0, 0, 2, 6, 0, 'h00, 'h66, 'h11);
        vt[9]  = mk(0, 0, 1, 0, 3, 3, 0, 'h00, 'h33, 'h33);
        vt[10] = mk(1, 0, 0, 0, 3, 3, 7, 'hC7, 'h33, 'h33);
        vt[11] = mk(1, 1, 1, 3, 1, 7, 5, 'h55, 'hC7, 'hC7);
        vt[12] = mk(0, 0, 0, 0, 1, 7, 0, 'h00, 'hC7, 'h05);
        vt[13] = mk(0, 0, 0, 0, 0, 5, 0, 'h00, 'h00, 'h55);

        {a_wc, a_co, a_sw, a_creq, a_sc, a_r1, a_r2, a_wr, a_wv} = '0;
        {b_wc, b_co, b_sw, b_creq, b_sc, b_r1, b_r2, b_wr, b_wv} = '0;
        a_rst = 1'b1; b_rst = 1'b1;
        tick(); tick();
        #1;
        check("rst_a_rv1", 32'(a_rv1), 0);
        check("rst_a_rv2", 32'(a_rv2), 0);
        check("rst_a_bv", 32'(a_bv), 0);
        check("rst_a_busy", 32'(a_busy), 0);
        check("rst_b_bv", 32'(b_bv), 0);
        check("rst_b_busy", 32'(b_busy), 0);
        a_rst = 1'b0; b_rst = 1'b0;
        tick();

        // Directed vector table
        for (int i = 0; i < 14; i++) begin
            a_wc = vt[i].wc; a_co = vt[i].co; a_sw = vt[i].sw; a_sc = vt[i].sc;
            a_r1 = vt[i].r1; a_r2 = vt[i].r2; a_wr = vt[i].wr; a_wv = vt[i].wv;
            #1;
            $display("vec %0d: rv1=%h rv2=%h (want %h %h)", i, a_rv1, a_rv2, vt[i].e1, vt[i].e2);
            check($sformatf("vec%0d_rv1", i), 32'(a_rv1), 32'(vt[i].e1));
            check($sformatf("vec%0d_rv2", i), 32'(a_rv2), 32'(vt[i].e2));
            tick();
        end
        {a_wc, a_co, a_sw, a_sc} = '0;

        // Bulk clear: fill, pulse, count busy, drop a mid-clear write
        for (int i = 1; i < 8; i++) begin
            a_wc = 1'b1; a_wr = 3'(i); a_wv = 8'hFF;
            tick();
        end
        a_wc = 1'b0;
        #1;
        check("fill_bv", 32'(a_bv), 32'h0FF);
        a_creq = 1'b1;
        tick();
        a_creq = 1'b0;
        n = 0;
        for (int g = 0; g < 40; g++) begin
            #1;
            if (!a_busy) break;
            n++;
            a_wc = (n == 4); a_wr = 3'd2; a_wv = 8'hAA;
            tick();
        end
        $display("clear8: busy cycles=%0d", n);
        check("clear8_len", 32'(n), 7);
        a_wc = 1'b1; a_wr = 3'd3; a_wv = 8'h3A;
        tick();
        a_wc = 1'b0;
        for (int i = 0; i < 8; i++) begin
            a_r2 = 3'(i);
            #1;
            check($sformatf("clear8_reg%0d", i), 32'(a_rv2), (i == 3) ? 32'h3A : 32'h0);
            tick();
        end

        // Reset during clear cycle 3
        a_wc = 1'b1; a_wr = 3'd5; a_wv = 8'h55;
        tick();
        a_wc = 1'b0; a_creq = 1'b1;
        tick();
        a_creq = 1'b0;
        tick(); tick();
        a_rst = 1'b1;
        tick();
        a_rst = 1'b0; a_r2 = 3'd5;
        #1;
        check("rstclr_busy", 32'(a_busy), 0);
        check("rstclr_reg5", 32'(a_rv2), 0);
        a_creq = 1'b1;
        tick();
        a_creq = 1'b0;
        #1;
        check("rstclr_restart", 32'(a_busy), 1);
        n = 1;
        for (int g = 0; g < 40; g++) begin
            tick();
            #1;
            if (!a_busy) break;
            n++;
        end
        check("rstclr_len", 32'(n), 7);

        // 16 x 16-bit instance
        b_wc = 1'b1; b_wr = 4'd2; b_wv = 16'hA5A5;
        tick();
        b_wc = 1'b1; b_wr = 4'd0; b_wv = 16'hFFFF; b_r2 = 4'd2;
        #1;
        check("b_rd2", 32'(b_rv2), 32'hA5A5);
        tick();
        b_wc = 1'b0; b_r2 = 4'd0;
        #1;
        check("b_reg0", 32'(b_rv2), 0);
        for (int i = 1; i < 16; i++) begin
            b_wc = 1'b1; b_wr = 4'(i); b_wv = 16'hFFFF;
            tick();
        end
        b_wc = 1'b0; b_r1 = 3'd7;
        #1;
        check("b_fill_bv", 32'(b_bv), 32'hFFFF);
        check("b_fill_rv1", 32'(b_rv1), 32'hFFFF);
        b_creq = 1'b1;
        tick();
        b_creq = 1'b0;
        n = 0;
        for (int g = 0; g < 40; g++) begin
            #1;
            if (!b_busy) break;
            n++;
            tick();
        end
        $display("clear16: busy cycles=%0d", n);
        check("clear16_len", 32'(n), 15);
        for (int i = 0; i < 16; i++) begin
            b_r2 = 4'(i);
            #1;
            check($sformatf("clear16_reg%0d", i), 32'(b_rv2), 0);
            tick();
        end
        b_wc = 1'b1; b_wr = 4'd15; b_wv = 16'h1234;
        tick();
        b_wc = 1'b0; b_sc = 2'b11;
        #1;
        check("b_bv_track", 32'(b_bv), 32'h1234);
        check("b_rv1_br", 32'(b_rv1), 32'h1234);

        // Randomized traffic against the reference model
        a_rst = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) m[i] = 0;
        busy_left = 0;
        clr_next = 0;
        for (int c = 0; c < 400; c++) begin
            a_rst  = ($urandom_range(0, 63) == 0);
            a_wc   = 1'($urandom_range(0, 1));
            a_co   = ($urandom_range(0, 3) == 0);
            a_sw   = ($urandom_range(0, 3) == 0);
            a_sc   = 2'($urandom_range(0, 3));
            a_r1   = 2'($urandom_range(0, 3));
            a_r2   = 3'($urandom_range(0, 7));
            a_wr   = 3'($urandom_range(0, 7));
            a_wv   = 8'($urandom);
            a_creq = ($urandom_range(0, 24) == 0);
            #1;
            exp1 = a_sc[1] ? (a_sc[0] ? m[7] : m[1]) : m[a_r1];
            check("rnd_rv1", 32'(a_rv1), 32'(exp1));
            check("rnd_rv2", 32'(a_rv2), 32'(m[a_r2]));
            check("rnd_bv", 32'(a_bv), 32'(m[7]));
            check("rnd_busy", 32'(a_busy), (busy_left > 0) ? 32'd1 : 32'd0);
            tick();
            if (a_rst) begin
                for (int i = 0; i < 8; i++) m[i] = 0;
                busy_left = 0;
            end else if (busy_left > 0) begin
                m[clr_next] = 0;
                clr_next++;
                busy_left--;
            end else begin
                nm = m;
                if (a_wc) begin
                    nm[a_wr] = int'(a_wv);
                    if (a_co) nm[1] = 1;
                end
                if (a_sw && (3'(a_r1) != a_r2)) begin
                    nm[a_r1] = m[a_r2];
                    nm[a_r2] = m[a_r1];
                end
                nm[0] = 0;
                m = nm;
                if (a_creq) begin
                    busy_left = 7;
                    clr_next = 1;
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
